// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared constants for the ALU arbiter slice.
// The ALU function codes and datapath width are shared by the arbiter and by anything driving the shared ALU.
package alu_arb_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SLL  = 3'b001;
  localparam logic [2:0] ALU_SLT  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SR   = 3'b101;
  localparam logic [2:0] ALU_OR   = 3'b110;
  localparam logic [2:0] ALU_AND  = 3'b111;

  // With no grant, the ALU is parked on ADD 0+0.
  localparam logic [2:0] ALU_IDLE_FUNC = ALU_ADD;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// The search starts one past last_grant and wraps modulo NUM_REQ.
// The pointer register that holds last_grant lives in the parent.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  // Find the first valid requester after last_grant. The result is one-hot or zero.
  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    if (en) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = int'(last_grant) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = ID_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NUM_REQ requesters.
// Arbitration is round-robin. The result goes into a one-entry response stage tagged with the requester id.
// Optional build macro ALU_ARB_STATS_EN adds a saturating conflict_cnt output.
//
// Handshake rules:
// - A request transfers when req_valid[i] && req_ready[i].
// - A response transfers when resp_valid && resp_ready.
// - req_ready is combinational from req_valid and the response slot state.
// - A requester holds its valid and payload until it is granted.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]             conflict_cnt,
`endif
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*XLEN-1:0] req_a,
  input  logic [NUM_REQ*XLEN-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]    req_func,
  input  logic [NUM_REQ-1:0]      req_control,
  output logic [XLEN-1:0]         alu_in_A,
  output logic [XLEN-1:0]         alu_in_B,
  output logic [2:0]              alu_func,
  output logic                    alu_control,
  input  logic [XLEN-1:0]         alu_out,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [XLEN-1:0]         resp_data,
  output logic [ID_W-1:0]         resp_id
);

  logic               slot_free;
  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    last_grant;
  logic               any_grant;

  // A new result can enter when the slot is empty or is being drained this cycle.
  // Reset blocks all grants, so nothing in flight is captured.
  assign slot_free = !resp_valid || resp_ready;
  assign arb_en    = slot_free && !rst;
  assign any_grant = |grant;
  assign req_ready = grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .valid      (req_valid),
    .last_grant (last_grant),
    .en         (arb_en),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Steer the winner's operands to the shared ALU. With no winner, drive the idle ADD 0+0.
  always_comb begin
    alu_in_A    = '0;
    alu_in_B    = '0;
    alu_func    = ALU_IDLE_FUNC;
    alu_control = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alu_in_A    = req_a[XLEN*i +: XLEN];
        alu_in_B    = req_b[XLEN*i +: XLEN];
        alu_func    = req_func[3*i +: 3];
        alu_control = req_control[i];
      end
    end
  end

  // Response stage: capture on grant, drain on resp_ready, and otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (any_grant) begin
      resp_valid <= 1'b1;
      resp_data  <= alu_out;
      resp_id    <= grant_idx;
      last_grant <= grant_idx;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic multi_valid;
  assign multi_valid = ($countones(req_valid) >= 2);

  // Count cycles where a grant is made while two or more requesters contend. Saturates at 16'hFFFF.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (any_grant && multi_valid && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter.
// The bench models the shared ALU and supplies hand-computed expected results.
// Build with ALU_ARB_STATS_EN defined to also exercise conflict_cnt.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 2;

  logic                    clk;
  logic                    rst;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*32-1:0]   req_a;
  logic [NUM_REQ*32-1:0]   req_b;
  logic [NUM_REQ*3-1:0]    req_func;
  logic [NUM_REQ-1:0]      req_control;
  logic [31:0]             alu_in_A;
  logic [31:0]             alu_in_B;
  logic [2:0]              alu_func;
  logic                    alu_control;
  logic [31:0]             alu_out;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [31:0]             resp_data;
  logic [ID_W-1:0]         resp_id;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]             conflict_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [ID_W+31:0] exp_q[$];
  logic [31:0]      exp_res[NUM_REQ];

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef ALU_ARB_STATS_EN
    .conflict_cnt(conflict_cnt),
`endif
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_func    (req_func),
    .req_control (req_control),
    .alu_in_A    (alu_in_A),
    .alu_in_B    (alu_in_B),
    .alu_func    (alu_func),
    .alu_control (alu_control),
    .alu_out     (alu_out),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_id     (resp_id)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared combinational ALU model; control selects LUI pass-through on ADD and arithmetic shift on SR.
  always_comb begin
    alu_out = '0;
    case (alu_func)
      ALU_ADD:  alu_out = alu_control ? alu_in_A : alu_in_A + alu_in_B;
      ALU_SLL:  alu_out = alu_in_A << alu_in_B[4:0];
      ALU_SLT:  alu_out = ($signed(alu_in_A) < $signed(alu_in_B)) ? 32'd1 : 32'd0;
      ALU_SLTU: alu_out = (alu_in_A < alu_in_B) ? 32'd1 : 32'd0;
      ALU_XOR:  alu_out = alu_in_A ^ alu_in_B;
      ALU_SR:   alu_out = alu_control ? $unsigned($signed(alu_in_A) >>> alu_in_B[4:0])
                                      : alu_in_A >> alu_in_B[4:0];
      ALU_OR:   alu_out = alu_in_A | alu_in_B;
      default:  alu_out = alu_in_A & alu_in_B;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic c, input logic [31:0] e);
    req_valid[i]        = v;
    req_a[32*i +: 32]   = a;
    req_b[32*i +: 32]   = b;
    req_func[3*i +: 3]  = f;
    req_control[i]      = c;
    exp_res[i]          = e;
  endtask

  // Scoreboard push: each accepted request queues its hand-computed result tagged with the requester.
  // Reset discards everything outstanding.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) exp_q.push_back({ID_W'(i), exp_res[i]});
      end
    end
  end

  // Monitor: compare every response that the consumer accepts.
  always @(negedge clk) begin
    logic [ID_W+31:0] e;
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", resp_data, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check("resp_id", 32'(resp_id), 32'(e[ID_W+31:32]));
        check("resp_data", resp_data, e[31:0]);
      end
    end
  end

  initial begin
    logic [31:0] ba [4];
    logic [31:0] bb [4];
    logic [2:0]  bf [4];
    logic        bc [4];
    logic [31:0] be [4];
    ba = '{32'd1, 32'd1, 32'h0000_00F0, 32'h1234_5000};
    bb = '{32'd1, 32'hFFFF_FFFF, 32'h0000_000F, 32'd0};
    bf = '{ALU_ADD, ALU_SLTU, ALU_XOR, ALU_ADD};
    bc = '{1'b0, 1'b0, 1'b0, 1'b1};
    be = '{32'd2, 32'd1, 32'h0000_00FF, 32'h1234_5000};

    rst = 1'b1;
    resp_ready = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_func = '0; req_control = '0;
    exp_res[0] = '0; exp_res[1] = '0;

    // Reset values, with a request presented to show that grants are held off during reset
    set_req(0, 1'b1, 32'd9, 32'd9, ALU_OR, 1'b1, 32'd0);
    step(); step();
    at_neg();
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_alu_a", alu_in_A, 32'd0);
    check("rst_alu_func", 32'(alu_func), 32'd0);
    check("rst_alu_ctl", 32'(alu_control), 32'd0);
    step();
    set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd0);
    rst = 1'b0;
    step();

    // Single request
    resp_ready = 1'b1;
    set_req(0, 1'b1, 32'd5, 32'd7, ALU_ADD, 1'b0, 32'd12);
    at_neg();
    check("single_req_ready", 32'(req_ready), 32'b01);
    check("single_alu_a", alu_in_A, 32'd5);
    check("single_alu_b", alu_in_B, 32'd7);
    step();
    set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd0);
    at_neg();
    check("single_resp_valid", 32'(resp_valid), 32'd1);
    check("single_resp_data", resp_data, 32'd12);
    check("idle_alu_a", alu_in_A, 32'd0);
    step();

    // Contention: after reset, grants alternate starting at req0 (-8>>>1 = -4, 3<<2 = 12)
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 32'hFFFF_FFF8, 32'd1, ALU_SR, 1'b1, 32'hFFFF_FFFC);
    set_req(1, 1'b1, 32'd3, 32'd2, ALU_SLL, 1'b0, 32'd12);
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check("contend_grant", 32'(req_ready), (k % 2 == 0) ? 32'b01 : 32'b10);
      step();
    end
    set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd0);
    at_neg();
    step();

    // Backpressure: fill the slot with 30, then hold req1 off for 5 cycles
    resp_ready = 1'b0;
    set_req(0, 1'b1, 32'd10, 32'd20, ALU_ADD, 1'b0, 32'd30);
    at_neg();
    check("bp_first_grant", 32'(req_ready), 32'b01);
    step();
    set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd0);
    set_req(1, 1'b1, 32'd100, 32'd1, ALU_ADD, 1'b0, 32'd101);
    for (int k = 0; k < 5; k++) begin
      at_neg();
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_data", resp_data, 32'd30);
      check("bp_resp_id", 32'(resp_id), 32'd0);
      step();
    end
    resp_ready = 1'b1;
    at_neg();
    check("bp_release_grant", 32'(req_ready), 32'b10);
    step();
    set_req(1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd0);
    at_neg();
    check("bp_after_data", resp_data, 32'd101);
    check("bp_after_id", 32'(resp_id), 32'd1);
    step();

    // Back-to-back on req0 with no bubbles
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, ba[k], bb[k], bf[k], bc[k], be[k]);
      at_neg();
      check("b2b_grant", 32'(req_ready), 32'b01);
      if (k > 0) check("b2b_resp_valid", 32'(resp_valid), 32'd1);
      step();
    end
    set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd0);
    at_neg();
    step();

    // Reset mid-operation; last grant was req0, so req1 wins first
    set_req(0, 1'b1, 32'd1, 32'd2, ALU_ADD, 1'b0, 32'd3);
    set_req(1, 1'b1, 32'd4, 32'd5, ALU_ADD, 1'b0, 32'd9);
    at_neg();
    check("rmid_grant1", 32'(req_ready), 32'b10);
    step();
    at_neg();
    check("rmid_grant0", 32'(req_ready), 32'b01);
    check("rmid_resp_valid", 32'(resp_valid), 32'd1);
    step();
    rst = 1'b1;
    at_neg();
    check("rmid_rst_ready", 32'(req_ready), 32'd0);
    check("rmid_rst_alu_a", alu_in_A, 32'd0);
    step();
    at_neg();
    check("rmid_after_valid", 32'(resp_valid), 32'd0);
    check("rmid_after_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    at_neg();
    check("rmid_first_grant", 32'(req_ready), 32'b01);
    step();
    set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd0);
    at_neg();
    step();

`ifdef ALU_ARB_STATS_EN
    // Conflict counter: 10 contended grants, then saturation from 16'hFFFE
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 32'd1, 32'd1, ALU_ADD, 1'b0, 32'd2);
    set_req(1, 1'b1, 32'd6, 32'd3, ALU_OR, 1'b0, 32'd7);
    repeat (10) step();
    set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd0);
    at_neg();
    check("stats_cnt10", 32'(conflict_cnt), 32'd10);
    step();
    force dut.conflict_cnt = 16'hFFFE;
    step();
    release dut.conflict_cnt;
    set_req(0, 1'b1, 32'd1, 32'd1, ALU_ADD, 1'b0, 32'd2);
    set_req(1, 1'b1, 32'd6, 32'd3, ALU_OR, 1'b0, 32'd7);
    repeat (3) step();
    set_req(0, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd0);
    set_req(1, 1'b0, 32'd0, 32'd0, ALU_ADD, 1'b0, 32'd0);
    at_neg();
    check("stats_sat", 32'(conflict_cnt), 32'hFFFF);
    step();
`endif

    // Final report
    repeat (2) step();
    at_neg();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
